// File: rtl/asm_pkg.sv
// ---------------------------------------------------------------------------
// asm_pkg
// Shared definitions for the ASM per-nibble code interface:
//   - nibble / code-field geometry
//   - alphabet value of a SEL code
//   - post-accumulate FSM state encoding
//   - bit offset of nibble i inside a packed SEL/SL code vector
// ---------------------------------------------------------------------------
package asm_pkg;

    localparam int NIBBLE_WIDTH      = 4;
    localparam int LOG2_NIBBLE_WIDTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Odd alphabet {1,3,5,7} selected by a 2-bit code.
    function automatic logic [2:0] alph(input logic [LOG2_NIBBLE_WIDTH-1:0] sel);
        return {sel, 1'b1};
    endfunction

    // LSB position of nibble i's field in a packed code vector.
    function automatic int code_lsb(input int nibble);
        return nibble * LOG2_NIBBLE_WIDTH;
    endfunction

endpackage

// File: rtl/asm_alphabet_precompute.sv
// ---------------------------------------------------------------------------
// asm_alphabet_precompute
// Registers the four odd multiples of B used by the accumulator.
// Only adds/subtracts of shifted B are used; no multiplier.
// Ports:
//   clk, rst      clock / synchronous active-high reset
//   i_en          load the multiples this cycle
//   i_b           multiplicand B
//   o_m1..o_m7    registered 1B, 3B, 5B, 7B (WIDTH+3 bits)
// ---------------------------------------------------------------------------
module asm_alphabet_precompute #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH+2:0] o_m1,
    output logic [WIDTH+2:0] o_m3,
    output logic [WIDTH+2:0] o_m5,
    output logic [WIDTH+2:0] o_m7
);

    localparam int MW = WIDTH + 3;

    logic [MW-1:0] w_b;

    assign w_b = MW'(i_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_m1 <= '0;
            o_m3 <= '0;
            o_m5 <= '0;
            o_m7 <= '0;
        end else if (i_en) begin
            o_m1 <= w_b;
            o_m3 <= w_b + (w_b << 1);
            o_m5 <= w_b + (w_b << 2);
            // 8B-B cannot underflow and 8B fits in WIDTH+3 bits.
            o_m7 <= (w_b << 3) - w_b;
        end
    end

endmodule

// File: rtl/asm_post_accumulate.sv
// ---------------------------------------------------------------------------
// asm_post_accumulate
// Rebuilds the approximate product from the per-nibble {SEL,SL} codes of A
// and multiplicand B: P = sum over nibbles of NZ_i * (alph(SEL_i)*B << SL_i) << 4i.
// One nibble is added per cycle after a one-cycle precompute of {1,3,5,7}*B.
// One operation in flight; result offered on a valid/ready handshake.
// Ports:
//   clk, rst              clock / synchronous active-high reset
//   in_valid, in_ready    input handshake (accepted only in IDLE)
//   SL_in, SEL_in         packed 2-bit codes, nibble i at [2i+1:2i]
//   NZ_in                 nibble-nonzero mask
//   B                     unsigned multiplicand
//   out_valid, out_ready  output handshake
//   P                     unsigned product, 2*WIDTH+2 bits
// ---------------------------------------------------------------------------
module asm_post_accumulate
    import asm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [LOG2_NIBBLE_WIDTH*(WIDTH/NIBBLE_WIDTH)-1:0]  SL_in,
    input  logic [LOG2_NIBBLE_WIDTH*(WIDTH/NIBBLE_WIDTH)-1:0]  SEL_in,
    input  logic [WIDTH/NIBBLE_WIDTH-1:0]                      NZ_in,
    input  logic [WIDTH-1:0]                                   B,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [2*WIDTH+1:0]                                 P
);

    localparam int NIBBLES = WIDTH / NIBBLE_WIDTH;
    localparam int PW      = 2 * WIDTH + 2;
    localparam int MW      = WIDTH + 3;
    localparam int CODEW   = LOG2_NIBBLE_WIDTH * NIBBLES;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int SHW     = $clog2(PW) + 1;

    state_t                       r_state;
    logic [CODEW-1:0]             r_sl;
    logic [CODEW-1:0]             r_sel;
    logic [NIBBLES-1:0]           r_nz;
    logic [WIDTH-1:0]             r_b;
    logic [CW-1:0]                r_cnt;
    logic [PW-1:0]                r_acc;
    logic [PW-1:0]                r_p;
    logic                         r_out_valid;

    logic [MW-1:0]                w_m1, w_m3, w_m5, w_m7;
    logic [LOG2_NIBBLE_WIDTH-1:0] w_sel;
    logic [LOG2_NIBBLE_WIDTH-1:0] w_sl;
    logic                         w_nz;
    logic [MW-1:0]                w_mult;
    logic [SHW-1:0]               w_shamt;
    logic [PW-1:0]                w_term;
    logic                         w_last;

    asm_alphabet_precompute #(
        .WIDTH (WIDTH)
    ) u_precompute (
        .clk  (clk),
        .rst  (rst),
        .i_en (r_state == ST_PRE),
        .i_b  (r_b),
        .o_m1 (w_m1),
        .o_m3 (w_m3),
        .o_m5 (w_m5),
        .o_m7 (w_m7)
    );

    // Term for the nibble selected by the counter.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_sel  = '0;
        w_sl   = '0;
        w_nz   = 1'b0;
        w_mult = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_cnt == CW'(i)) begin
                w_sel = r_sel[code_lsb(i) +: LOG2_NIBBLE_WIDTH];
                w_sl  = r_sl[code_lsb(i) +: LOG2_NIBBLE_WIDTH];
                w_nz  = r_nz[i];
            end
        end
        case (w_sel)
            2'd0:    w_mult = w_m1;
            2'd1:    w_mult = w_m3;
            2'd2:    w_mult = w_m5;
            default: w_mult = w_m7;
        endcase
        w_shamt = SHW'(w_sl) + SHW'(r_cnt) * SHW'(NIBBLE_WIDTH);
        w_term  = w_nz ? (PW'(w_mult) << w_shamt) : '0;
    end

    assign w_last = (r_cnt == CW'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sl        <= '0;
            r_sel       <= '0;
            r_nz        <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_p         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sl    <= SL_in;
                        r_sel   <= SEL_in;
                        r_nz    <= NZ_in;
                        r_b     <= B;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    r_state <= ST_ACC;
                end
                ST_ACC: begin
                    r_acc <= r_acc + w_term;
                    if (w_last) begin
                        // P is only updated here, so it holds through DONE and IDLE.
                        r_p         <= r_acc + w_term;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Gated by rst so the block never advertises readiness while held in reset.
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign P         = r_p;

endmodule

// File: tb/tb_asm_post_accumulate.sv
// ---------------------------------------------------------------------------
// tb_asm_post_accumulate
// Directed and randomized checks of asm_post_accumulate at WIDTH=8, plus a
// WIDTH=32 full-scale case. Expected products come from an arithmetic model
// of the nibble-term sum.
// ---------------------------------------------------------------------------
module tb_asm_post_accumulate;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0;
    logic [3:0]  sl8 = '0, sel8 = '0;
    logic [1:0]  nz8 = '0;
    logic [7:0]  b8 = '0;
    logic [17:0] p8;

    // WIDTH=32 instance
    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b0;
    logic [15:0] sl32 = '0, sel32 = '0;
    logic [7:0]  nz32 = '0;
    logic [31:0] b32 = '0;
    logic [65:0] p32;

    asm_post_accumulate #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .SL_in(sl8), .SEL_in(sel8), .NZ_in(nz8), .B(b8),
        .out_valid(ov8), .out_ready(or8), .P(p8)
    );

    asm_post_accumulate #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .SL_in(sl32), .SEL_in(sel32), .NZ_in(nz32), .B(b32),
        .out_valid(ov32), .out_ready(or32), .P(p32)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sum of nibble terms: NZ_i * ((2*SEL_i+1) * B) * 2^(SL_i + 4i).
    function automatic logic [65:0] model(input int n, input logic [15:0] sel,
                                          input logic [15:0] sl, input logic [7:0] nz,
                                          input logic [31:0] b);
        logic [65:0] acc;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            if (nz[i]) begin
                int a;
                int s;
                a = 2 * int'(sel[2*i +: 2]) + 1;
                s = int'(sl[2*i +: 2]) + 4 * i;
                acc = acc + ((66'(a) * 66'(b)) << s);
            end
        end
        return acc;
    endfunction

    task automatic start8(input logic [7:0] b, input logic [3:0] sel,
                          input logic [3:0] sl, input logic [1:0] nz);
        int k;
        k = 0;
        while (!ir8 && k < 20) begin
            tick();
            k++;
        end
        check("ready8_before_accept", 66'(ir8), 66'(1));
        b8 = b; sel8 = sel; sl8 = sl; nz8 = nz;
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        check("ready8_busy", 66'(ir8), 66'(0));
    endtask

    task automatic wait_valid8(input string tag);
        int cyc;
        cyc = 0;
        while (!ov8 && cyc < 50) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 66'(cyc), 66'(3));
    endtask

    task automatic handshake8(input string tag);
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check({tag, "_valid_drop"}, 66'(ov8), 66'(0));
        check({tag, "_ready_back"}, 66'(ir8), 66'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1;
        check("rst_in_ready", 66'(ir8), 66'(0));
        tick();
        tick();
        check("rst_out_valid", 66'(ov8), 66'(0));
        check("rst_p", 66'(p8), 66'(0));
        check("rst_in_ready_held", 66'(ir8), 66'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 66'(ir8), 66'(1));
        check("post_rst_in_ready32", 66'(ir32), 66'(1));

        // Test 1: A ~ 70 (nibble0 = 3<<1, nibble1 = 1<<2), B=10 -> 700
        start8(8'd10, 4'b0001, 4'b1001, 2'b11);
        check("t1_p_held_before_done", 66'(p8), 66'(0));
        wait_valid8("t1");
        check("t1_p", 66'(p8), 66'(700));
        handshake8("t1");

        // Test 2: nibble1 masked -> 60; both masked -> 0
        start8(8'd10, 4'b0001, 4'b1001, 2'b01);
        wait_valid8("t2a");
        check("t2a_p", 66'(p8), 66'(60));
        handshake8("t2a");
        start8(8'd10, 4'b0001, 4'b1001, 2'b00);
        wait_valid8("t2b");
        check("t2b_p", 66'(p8), 66'(0));
        handshake8("t2b");

        // Test 3: maximum codes at WIDTH=8
        start8(8'd255, 4'b1111, 4'b1111, 2'b11);
        wait_valid8("t3");
        check("t3_p", 66'(p8), 66'(242760));
        handshake8("t3");

        // Test 3b: maximum codes at WIDTH=32
        begin
            int cyc;
            logic [65:0] exp32;
            exp32 = model(8, 16'hFFFF, 16'hFFFF, 8'hFF, 32'hFFFF_FFFF);
            b32 = 32'hFFFF_FFFF; sel32 = 16'hFFFF; sl32 = 16'hFFFF; nz32 = 8'hFF;
            iv32 = 1'b1;
            tick();
            iv32 = 1'b0;
            cyc = 0;
            while (!ov32 && cyc < 50) begin
                tick();
                cyc++;
            end
            check("t3b_latency", 66'(cyc), 66'(9));
            check("t3b_p", p32, exp32);
            or32 = 1'b1;
            tick();
            or32 = 1'b0;
            check("t3b_valid_drop", 66'(ov32), 66'(0));
        end

        // Test 4: backpressure, in_valid pulses ignored while busy
        or8 = 1'b1;
        start8(8'd10, 4'b0001, 4'b1001, 2'b11);
        or8 = 1'b0;
        wait_valid8("t4");
        for (int i = 0; i < 5; i++) begin
            iv8 = (i == 2);
            b8 = 8'd99;
            check("t4_p_stable", 66'(p8), 66'(700));
            check("t4_valid_held", 66'(ov8), 66'(1));
            check("t4_in_ready_low", 66'(ir8), 66'(0));
            tick();
        end
        iv8 = 1'b0;
        check("t4_p_after_stall", 66'(p8), 66'(700));
        handshake8("t4");
        for (int i = 0; i < 5; i++) tick();
        check("t4_no_ghost_op", 66'(ov8), 66'(0));
        check("t4_p_held_idle", 66'(p8), 66'(700));

        // Test 5: reset during ACC aborts the operation
        start8(8'd200, 4'b1111, 4'b1111, 2'b11);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t5_valid_after_rst", 66'(ov8), 66'(0));
        check("t5_p_after_rst", 66'(p8), 66'(0));
        check("t5_ready_in_rst", 66'(ir8), 66'(0));
        rst = 1'b0;
        #1;
        check("t5_idle_after_rst", 66'(ir8), 66'(1));
        for (int i = 0; i < 4; i++) tick();
        check("t5_no_partial_p", 66'(ov8), 66'(0));
        start8(8'd3, 4'b0011, 4'b0000, 2'b11);
        wait_valid8("t5");
        check("t5_p", 66'(p8), 66'(69));
        handshake8("t5");

        // Test 6: random traffic against a scoreboard
        begin
            logic [17:0] q[$];
            int done;
            int cyc;
            done = 0;
            cyc = 0;
            while (done < 40 && cyc < 4000) begin
                iv8  = ($urandom_range(0, 1) == 1);
                b8   = 8'($urandom);
                sel8 = 4'($urandom);
                sl8  = 4'($urandom);
                nz8  = 2'($urandom);
                or8  = ($urandom_range(0, 2) != 0);
                if (iv8 && ir8) begin
                    q.push_back(18'(model(2, 16'(sel8), 16'(sl8), 8'(nz8), 32'(b8))));
                end
                if (ov8 && or8) begin
                    check("t6_result_expected", 66'(q.size() > 0), 66'(1));
                    if (q.size() > 0) check("t6_p", 66'(p8), 66'(q.pop_front()));
                    done++;
                end
                tick();
                cyc++;
            end
            iv8 = 1'b0;
            or8 = 1'b0;
            check("t6_ops_completed", 66'(done), 66'(40));
            check("t6_none_outstanding", 66'(q.size()), 66'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
